// File: rtl/unsigned_div_pkg.sv
// rtl/unsigned_div_pkg.sv - shared width default and FSM state type for the restoring divider
package unsigned_div_pkg;

    // Default divisor/quotient width; the dividend is twice this.
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/unsigned_div_step.sv
// rtl/unsigned_div_step.sv - one combinational compare-subtract step of a restoring divider
//
// Ports:
//   r       in   W   partial remainder entering this step (always < y)
//   bit_in  in   1   next dividend bit shifted into the remainder
//   y       in   W   divisor
//   r_next  out  W   partial remainder leaving this step
//   q_bit   out  1   quotient bit produced by this step
module unsigned_div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic         bit_in,
    input  logic [W-1:0] y,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    // Trial value is one bit wider than the divisor so the compare and
    // subtract can never wrap.
    logic [W:0] t;
    logic [W:0] y_ext;

    always_comb begin
        t      = {r, bit_in};
        y_ext  = {1'b0, y};
        q_bit  = (t >= y_ext);
        // When the subtract is taken the difference is < y, so the top bit is
        // always zero; when it is not, t < y and t[W] is zero as well.
        r_next = q_bit ? W'(t - y_ext) : t[W-1:0];
    end

endmodule

// File: rtl/unsigned_restoring_div_16by8_l2.sv
// rtl/unsigned_restoring_div_16by8_l2.sv - sequential unsigned 2W/W restoring divider with L truncated quotient LSBs
//
// Ports:
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous active-high reset
//   in_valid   in   1     operands valid
//   in_ready   out  1     divider idle and able to accept operands
//   z          in   2W    dividend
//   y          in   W     divisor
//   out_valid  out  1     result valid, held until out_ready
//   out_ready  in   1     consumer accepts result
//   x          out  W     quotient (low L bits forced to zero)
//   rem        out  W+L   remainder; z == x*y + rem when ovf is low
//   ovf        out  1     divide by zero or quotient would not fit in W bits
module unsigned_restoring_div_16by8_l2
    import unsigned_div_pkg::*;
#(
    parameter int W = DIV_W,
    parameter int L = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   z,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     x,
    output logic [W+L-1:0]   rem,
    output logic             ovf
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int RW    = W + L;
    // Selects the dividend bits below the last computed quotient position;
    // they pass straight into the remainder.
    localparam logic [W-1:0] LOW_MASK = W'((1 << L) - 1);

    state_t             state;
    logic [W-1:0]       y_q;
    logic [W-1:0]       z_lo_q;
    logic [W-1:0]       r_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       q_q;
    logic [RW-1:0]      rem_q;
    logic               ovf_q;

    logic               ovf_cond;
    logic [W-1:0]       r_next;
    logic               q_bit;
    logic [RW-1:0]      rem_calc;

    // Upper half already >= divisor means the quotient needs more than W bits.
    assign ovf_cond = (y == '0) || (z[2*W-1:W] >= y);

    unsigned_div_step #(
        .W (W)
    ) u_step (
        .r      (r_q),
        .bit_in (z_lo_q[cnt_q]),
        .y      (y_q),
        .r_next (r_next),
        .q_bit  (q_bit)
    );

    // Final remainder: the last partial remainder, scaled back up by the
    // skipped iterations, with the untouched dividend LSBs appended.
    assign rem_calc = (RW'(r_next) << L) | RW'(z_lo_q & LOW_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            y_q    <= '0;
            z_lo_q <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        y_q    <= y;
                        z_lo_q <= z[W-1:0];
                        rem_q  <= '0;
                        if (ovf_cond) begin
                            q_q   <= '1;
                            r_q   <= '0;
                            ovf_q <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            q_q   <= '0;
                            r_q   <= z[2*W-1:W];
                            cnt_q <= CNT_W'(W - 1);
                            ovf_q <= 1'b0;
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    q_q[cnt_q] <= q_bit;
                    r_q        <= r_next;
                    if (cnt_q == CNT_W'(L)) begin
                        rem_q <= rem_calc;
                        state <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign x         = q_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;

endmodule
